// File: rtl/bht_predictor.sv
// IF-stage branch predictor: decodes jal/jalr/branch and predicts direction from a PC-indexed
// table of saturating counters. Define BHT_PREDICTOR_RAS_EN to add a return-address stack.
module bht_predictor #(
    parameter int ADDR_W    = 32,
    parameter int INDEX_W   = 8,
    parameter int CTR_W     = 2,
    parameter int RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rdy,
    input  logic              if_valid,
    input  logic [ADDR_W-1:0] if_pc,
    input  logic [31:0]       if_instr,
    output logic              is_jump_instr,
    output logic              predicted_jump,
    output logic [ADDR_W-1:0] predict_jump_pc,
    output logic              pred_valid,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_taken
);

    localparam int TBL_SIZE = 2 ** INDEX_W;
    localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'((2 ** (CTR_W - 1)) - 1);
    localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};

    localparam logic [6:0] OP_JAL    = 7'd111;
    localparam logic [6:0] OP_JALR   = 7'd103;
    localparam logic [6:0] OP_BRANCH = 7'd99;

    logic [CTR_W-1:0]   ctr [TBL_SIZE];
    logic [INDEX_W-1:0] q_idx;
    logic [INDEX_W-1:0] u_idx;
    logic               upd_pc_unused;

    logic [6:0]         opcode;
    logic [20:0]        imm_j;
    logic [12:0]        imm_b;
    logic [ADDR_W-1:0]  pc_plus4;
    logic [ADDR_W-1:0]  jal_target;
    logic [ADDR_W-1:0]  br_target;

    logic               nxt_jump;
    logic               nxt_taken;
    logic [ADDR_W-1:0]  nxt_target;

    assign q_idx         = if_pc[INDEX_W+1:2];
    assign u_idx         = upd_pc[INDEX_W+1:2];
    assign upd_pc_unused = ^{upd_pc[ADDR_W-1:INDEX_W+2], upd_pc[1:0]};

    assign opcode     = if_instr[6:0];
    assign imm_j      = {if_instr[31], if_instr[19:12], if_instr[20], if_instr[30:21], 1'b0};
    assign imm_b      = {if_instr[31], if_instr[7], if_instr[30:25], if_instr[11:8], 1'b0};
    assign pc_plus4   = if_pc + ADDR_W'(4);
    assign jal_target = if_pc + {{(ADDR_W-21){imm_j[20]}}, imm_j};
    assign br_target  = if_pc + {{(ADDR_W-13){imm_b[12]}}, imm_b};

`ifdef BHT_PREDICTOR_RAS_EN
    localparam int RAS_PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam logic [RAS_PW-1:0] RAS_LAST = RAS_PW'(RAS_DEPTH - 1);
    localparam logic [RAS_PW:0]   RAS_FULL = (RAS_PW + 1)'(RAS_DEPTH);

    logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
    logic [RAS_PW-1:0] ras_ptr;    // next slot to write; top of stack is the slot before it
    logic [RAS_PW:0]   ras_cnt;
    logic [RAS_PW-1:0] ras_top;
    logic [RAS_PW-1:0] ras_ptr_inc;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic              is_call;
    logic              is_ret;
    logic              ret_hit;

    assign rd          = if_instr[11:7];
    assign rs1         = if_instr[19:15];
    assign ras_top     = (ras_ptr == '0) ? RAS_LAST : ras_ptr - 1'b1;
    assign ras_ptr_inc = (ras_ptr == RAS_LAST) ? '0 : ras_ptr + 1'b1;
    assign is_call     = ((opcode == OP_JAL) || (opcode == OP_JALR)) &&
                         ((rd == 5'd1) || (rd == 5'd5));
    assign is_ret      = (opcode == OP_JALR) && (rd == 5'd0) && (rs1 == 5'd1);
    assign ret_hit     = is_ret && (ras_cnt != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ras_ptr <= '0;
            ras_cnt <= '0;
        end else if (rdy && if_valid) begin
            if (is_call) begin
                ras_ptr <= ras_ptr_inc;
                if (ras_cnt != RAS_FULL) ras_cnt <= ras_cnt + 1'b1;
            end else if (ret_hit) begin
                ras_ptr <= ras_top;
                ras_cnt <= ras_cnt - 1'b1;
            end
        end
    end

    // Entries need no reset: they are only read while the count says they were written.
    always_ff @(posedge clk) begin
        if (rdy && if_valid && is_call) ras_mem[ras_ptr] <= pc_plus4;
    end
`endif

    always_comb begin
        nxt_jump   = 1'b0;
        nxt_taken  = 1'b0;
        nxt_target = pc_plus4;
        case (opcode)
            OP_JAL: begin
                nxt_jump   = 1'b1;
                nxt_taken  = 1'b1;
                nxt_target = jal_target;
            end
            OP_BRANCH: begin
                nxt_jump  = 1'b1;
                nxt_taken = ctr[q_idx][CTR_W-1];
                if (ctr[q_idx][CTR_W-1]) nxt_target = br_target;
            end
            OP_JALR: begin
                nxt_jump = 1'b1;
`ifdef BHT_PREDICTOR_RAS_EN
                if (ret_hit) begin
                    nxt_taken  = 1'b1;
                    nxt_target = ras_mem[ras_top];
                end
`endif
            end
            default: ;
        endcase
    end

    // Query reads the counter before this edge's update lands, so same-index updates are not seen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TBL_SIZE; i++) ctr[i] <= CTR_INIT;
        end else if (rdy && upd_valid) begin
            if (upd_taken) begin
                if (ctr[u_idx] != CTR_MAX) ctr[u_idx] <= ctr[u_idx] + 1'b1;
            end else begin
                if (ctr[u_idx] != '0) ctr[u_idx] <= ctr[u_idx] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_jump_instr   <= 1'b0;
            predicted_jump  <= 1'b0;
            predict_jump_pc <= '0;
            pred_valid      <= 1'b0;
        end else if (rdy) begin
            if (if_valid) begin
                is_jump_instr   <= nxt_jump;
                predicted_jump  <= nxt_taken;
                predict_jump_pc <= nxt_target;
                pred_valid      <= 1'b1;
            end else begin
                pred_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bht_predictor.sv
// Directed self-checking bench for bht_predictor; RAS steps run when BHT_PREDICTOR_RAS_EN is defined.
module tb_bht_predictor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rdy;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        is_jump_instr;
    logic        predicted_jump;
    logic [31:0] predict_jump_pc;
    logic        pred_valid;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [31:0] ADDI = 32'h0010_0093;   // addi x1, x0, 1
    localparam logic [31:0] RET  = 32'h0000_8067;   // jalr x0, 0(x1)
    localparam logic [31:0] JR5  = 32'h0002_8067;   // jalr x0, 0(x5)

    bht_predictor #(.ADDR_W(32), .INDEX_W(8), .CTR_W(2), .RAS_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy),
        .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
        .is_jump_instr(is_jump_instr), .predicted_jump(predicted_jump),
        .predict_jump_pc(predict_jump_pc), .pred_valid(pred_valid),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] enc_br(input logic [12:0] imm);
        return {imm[12], imm[10:5], 5'd0, 5'd0, 3'b000, imm[4:1], imm[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_jal(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_pred(input string tag, input logic j, input logic t,
                            input logic [31:0] pc, input logic v);
        chk({tag, ".jump"},  {31'd0, is_jump_instr},  {31'd0, j});
        chk({tag, ".taken"}, {31'd0, predicted_jump}, {31'd0, t});
        chk({tag, ".pc"},    predict_jump_pc,         pc);
        chk({tag, ".valid"}, {31'd0, pred_valid},     {31'd0, v});
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic query(input logic [31:0] pc, input logic [31:0] instr);
        if_valid = 1'b1;
        if_pc    = pc;
        if_instr = instr;
        cyc();
        if_valid = 1'b0;
    endtask

    task automatic upd(input logic [31:0] pc, input logic taken, input int n);
        for (int k = 0; k < n; k++) begin
            upd_valid = 1'b1;
            upd_pc    = pc;
            upd_taken = taken;
            cyc();
        end
        upd_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; rdy = 1'b1; if_valid = 1'b0; if_pc = '0; if_instr = '0;
        upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0;
        cyc();
        chk_pred("reset", 1'b0, 1'b0, 32'h0, 1'b0);
        rst_n = 1'b1;
        cyc();

        query(32'h100, enc_br(13'd16));
        chk_pred("br_init", 1'b1, 1'b0, 32'h104, 1'b1);
        cyc();
        chk_pred("idle_hold", 1'b1, 1'b0, 32'h104, 1'b0);

        upd(32'h100, 1'b1, 2);
        query(32'h100, enc_br(13'd16));
        chk_pred("br_ctr3", 1'b1, 1'b1, 32'h110, 1'b1);
        upd(32'h100, 1'b1, 5);
        query(32'h100, enc_br(13'd16));
        chk_pred("br_sat_hi", 1'b1, 1'b1, 32'h110, 1'b1);
        upd(32'h100, 1'b0, 1);
        query(32'h100, enc_br(13'd16));
        chk_pred("br_ctr2", 1'b1, 1'b1, 32'h110, 1'b1);
        upd(32'h100, 1'b0, 2);
        query(32'h100, enc_br(13'd16));
        chk_pred("br_ctr0", 1'b1, 1'b0, 32'h104, 1'b1);
        upd(32'h100, 1'b0, 1);
        upd(32'h100, 1'b1, 1);
        query(32'h100, enc_br(13'd16));
        chk_pred("br_sat_lo", 1'b1, 1'b0, 32'h104, 1'b1);

        query(32'h200, enc_jal(-21'sd8, 5'd0));
        chk_pred("jal_back", 1'b1, 1'b1, 32'h1F8, 1'b1);
        query(32'h300, ADDI);
        chk_pred("addi", 1'b0, 1'b0, 32'h304, 1'b1);
        query(32'h310, JR5);
        chk_pred("jalr", 1'b1, 1'b0, 32'h314, 1'b1);

        // Same-cycle update and query on a fresh index: query must see the old counter.
        upd_valid = 1'b1; upd_pc = 32'h180; upd_taken = 1'b1;
        query(32'h180, enc_br(13'd16));
        upd_valid = 1'b0;
        chk_pred("same_cyc", 1'b1, 1'b0, 32'h184, 1'b1);
        query(32'h180, enc_br(13'd16));
        chk_pred("same_cyc_after", 1'b1, 1'b1, 32'h190, 1'b1);

        query(32'hFFFF_FFFC, enc_jal(21'd8, 5'd0));
        chk_pred("jal_wrap", 1'b1, 1'b1, 32'h4, 1'b1);

        rdy = 1'b0;
        if_valid = 1'b1; if_pc = 32'h500; if_instr = ADDI;
        upd_valid = 1'b1; upd_pc = 32'h200; upd_taken = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk_pred("rdy_low", 1'b1, 1'b1, 32'h4, 1'b1);
        end
        if_valid = 1'b0; upd_valid = 1'b0; rdy = 1'b1;
        query(32'h200, enc_br(13'd16));
        chk_pred("rdy_no_upd", 1'b1, 1'b0, 32'h204, 1'b1);

        upd(32'h100, 1'b1, 2);
        query(32'h100, enc_br(13'd16));
        chk_pred("pre_rst", 1'b1, 1'b1, 32'h110, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk_pred("async_rst", 1'b0, 1'b0, 32'h0, 1'b0);
        #1 rst_n = 1'b1;
        query(32'h100, enc_br(13'd16));
        chk_pred("post_rst", 1'b1, 1'b0, 32'h104, 1'b1);
        upd(32'h100, 1'b1, 1);
        query(32'h100, enc_br(13'd16));
        chk_pred("post_rst_01", 1'b1, 1'b1, 32'h110, 1'b1);

`ifdef BHT_PREDICTOR_RAS_EN
        query(32'h400, enc_jal(21'h40, 5'd1));
        chk_pred("ras_call", 1'b1, 1'b1, 32'h440, 1'b1);
        query(32'h440, RET);
        chk_pred("ras_ret", 1'b1, 1'b1, 32'h404, 1'b1);
        for (int k = 0; k < 5; k++) query(32'h1000 + 32'(k * 16), enc_jal(21'h100, 5'd1));
        for (int k = 0; k < 4; k++) begin
            query(32'h2000, RET);
            chk_pred("ras_lifo", 1'b1, 1'b1, 32'h1044 - 32'(k * 16), 1'b1);
        end
        query(32'h2000, RET);
        chk_pred("ras_empty", 1'b1, 1'b0, 32'h2004, 1'b1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bht_predictor.md
Name: bht_predictor

Overview:
- Parametrised branch predictor for the IF stage; successor to the fixed always-taken/static predictor.
- Decodes the fetched instruction and computes the jump target for jal and branch instructions.
- Branch direction comes from a PC-indexed table of saturating counters.
- The ROB trains the table on every resolved jump.

Parameters:
- ADDR_W, 32, PC/address width.
- INDEX_W, 8, table index bits; table has 2^INDEX_W entries.
- CTR_W, 2, saturating counter width (>=1).
- RAS_DEPTH, 4, return-stack entries (used only with RAS_EN).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- rdy  in  1  global ready; when low all state and outputs hold.
- if_valid  in  1  a fetched instruction is presented this cycle.
- if_pc  in  ADDR_W  PC of the fetched instruction.
- if_instr  in  32  fetched instruction word.
- is_jump_instr  out  1  registered; instruction is jal/jalr/branch.
- predicted_jump  out  1  registered; predicted taken.
- predict_jump_pc  out  ADDR_W  registered; predicted next PC.
- pred_valid  out  1  registered; outputs correspond to last accepted query.
- upd_valid  in  1  ROB resolved a branch this cycle.
- upd_pc  in  ADDR_W  PC of the resolved branch.
- upd_taken  in  1  actual outcome.

Behaviour:
- Reset (async, rst_n=0):
  - All counters = 2^(CTR_W-1)-1 (weakly not-taken; 01 for CTR_W=2).
  - is_jump_instr=0, predicted_jump=0, predict_jump_pc=0, pred_valid=0.
  - RAS pointer/count = 0.
  - Reset mid-operation discards any in-flight query or update.
- Latency:
  - Query accepted on the edge with rdy=1 & if_valid=1; outputs valid next cycle with pred_valid=1.
  - If if_valid=0 (rdy=1), pred_valid drops to 0 and the other outputs hold.
- Index: idx = pc[INDEX_W+1:2].
- Decode (opcode = if_instr[6:0]):
  - 111 (jal): jump=1, taken=1, target = if_pc + sext({i[31],i[19:12],i[20],i[30:21],0}).
  - 99 (branch): jump=1, taken = ctr[idx] MSB, target = if_pc + sext({i[31],i[7],i[30:25],i[11:8],0}) when taken, else if_pc+4.
  - 103 (jalr): jump=1, taken=0, target = if_pc+4 (overridden under RAS_EN).
  - Other opcodes: jump=0, taken=0, target = if_pc+4.
- Address arithmetic is modulo 2^ADDR_W; wrap-around is allowed and is not flagged.
- Update (rdy=1 & upd_valid=1):
  - ctr[upd idx] increments if upd_taken, decrements otherwise.
  - Saturates at 2^CTR_W-1 and at 0; no wrap.
- Simultaneous query and update to the same index: the query uses the pre-update counter value; the write commits on the same edge.
- rdy=0: no table writes, no RAS change, outputs frozen.

Optional Feature:
- Macro: BHT_PREDICTOR_RAS_EN.
- Enabled, a RAS_DEPTH circular return-address stack is added:
  - Push: jal or jalr with rd=x1 or x5 pushes if_pc+4 at query acceptance.
  - Pop: jalr with rd=x0 and rs1=x1 is a return. If the stack is non-empty, the entry is popped and the block outputs taken=1, target = popped value.
  - Empty stack on return: no pop; taken=0, target = if_pc+4.
  - Full stack on push: overwrites the oldest entry; count saturates at RAS_DEPTH.
  - Push and pop never occur on the same instruction; a call through jalr with rd=x1 pushes only.
- Disabled: jalr is always not-taken with target if_pc+4; no stack storage exists.

Test Plan:
- Reset, then query branch at pc=0x100 with imm=+16 -> next cycle is_jump_instr=1, predicted_jump=0, predict_jump_pc=0x104, pred_valid=1.
- Two updates taken at pc=0x100, then re-query -> predicted_jump=1, predict_jump_pc=0x110. Five more taken updates -> counter stays 3. Three not-taken updates -> counter 0, predict 0x104.
- jal at pc=0x200 with imm=-8 -> taken=1, target 0x1F8. addi at 0x300 -> is_jump_instr=0, target 0x304.
- Same-cycle update (taken) and query of idx from counter 01 -> query predicts not-taken; a following query predicts taken.
- rdy=0 for 3 cycles while if_valid and upd_valid are asserted -> outputs and counters unchanged. rst_n pulsed low mid-stream -> outputs 0 immediately (async), counters back to 01.
- RAS_EN: jal ra at 0x400 followed by ret -> ret predicted taken to 0x404. Five calls with RAS_DEPTH=4 then five rets -> the first four pop in LIFO order; the fifth ret predicts if_pc+4, not-taken.
